// File: rtl/nn_pkg.sv
// Shared fixed-point helpers, FSM state encoding and width defaults for the
// time-multiplexed dense layer.
package nn_pkg;

    localparam int NUM_WIDTH_DEF = 16;
    localparam int FRAC_BITS_DEF = 8;

    // All arithmetic runs on a wide signed carrier and is clamped back to the word width.
    typedef logic signed [63:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        UPD  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic wide_t sat_clamp(input wide_t x, input int width);
        wide_t hi;
        wide_t lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width);
        return sat_clamp(a + b, width);
    endfunction

    function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int width);
        return sat_clamp(a - b, width);
    endfunction

    function automatic wide_t sat_mul(input wide_t a, input wide_t b, input int width,
                                      input int frac);
        return sat_clamp((a * b) >>> frac, width);
    endfunction

    function automatic wide_t leaky_relu(input wide_t x);
        if (x < 64'sd0) begin
            return x >>> 3;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Pass-control, operand/result and host weight-port bundle of dense_layer_seq.
interface dense_layer_seq_if #(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 4,
    parameter int NUM_WIDTH   = 16,
    parameter int INDEX_WIDTH = 4
);
    logic                         start;
    logic                         mode;
    logic                         act_sel;
    logic [N_IN*NUM_WIDTH-1:0]    a_pk;
    logic [N_OUT*NUM_WIDTH-1:0]   e_pk;
    logic [N_OUT*NUM_WIDTH-1:0]   z_pk;
    logic [N_OUT*NUM_WIDTH-1:0]   y_pk;
    logic                         busy;
    logic                         done;
    logic                         wu;
    logic [INDEX_WIDTH-1:0]       w_i;
    logic [INDEX_WIDTH-1:0]       w_j;
    logic [NUM_WIDTH-1:0]         w_in;
    logic [NUM_WIDTH-1:0]         w_out;

    modport master (
        output start, mode, act_sel, a_pk, e_pk, wu, w_i, w_j, w_in,
        input  z_pk, y_pk, busy, done, w_out
    );

    modport slave (
        input  start, mode, act_sel, a_pk, e_pk, wu, w_i, w_j, w_in,
        output z_pk, y_pk, busy, done, w_out
    );
endinterface

// File: rtl/fxp_mac_sat.sv
// Combinational saturating multiply-accumulate: acc' = sat((clear ? 0 : acc) + sat_mul(x, y)).
module fxp_mac_sat
    import nn_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [NUM_WIDTH-1:0] acc_i,
    input  logic signed [NUM_WIDTH-1:0] x_i,
    input  logic signed [NUM_WIDTH-1:0] y_i,
    input  logic                        clear_i,
    output logic signed [NUM_WIDTH-1:0] acc_o
);
    wide_t base_s;
    wide_t prod_s;
    wide_t sum_s;

    // Product and accumulate, each step clamped to the word range
    always_comb begin
        if (clear_i) begin
            base_s = 64'sd0;
        end else begin
            base_s = wide_t'(acc_i);
        end
        prod_s = sat_mul(wide_t'(x_i), wide_t'(y_i), NUM_WIDTH, FRAC_BITS);
        sum_s  = sat_add(base_s, prod_s, NUM_WIDTH);
        acc_o  = NUM_WIDTH'(sum_s);
    end
endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully connected layer: one shared saturating MAC walks every
// (neuron j, input i) pair per pass, either accumulating z/y or applying a delta-rule weight step.
module dense_layer_seq
    import nn_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 4,
    parameter int NUM_WIDTH   = NUM_WIDTH_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int LR_SHIFT    = 4,
    parameter int INDEX_WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    dense_layer_seq_if.slave bus
);
    localparam int IA = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int IO = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IA-1:0] I_LAST = IA'(N_IN - 1);
    localparam logic [IO-1:0] J_LAST = IO'(N_OUT - 1);

    state_t                                    state_q, state_d;
    logic [IA-1:0]                             i_q, i_d;
    logic [IO-1:0]                             j_q, j_d;
    logic signed [NUM_WIDTH-1:0]               acc_q, acc_d;
    logic [N_IN-1:0][N_OUT-1:0][NUM_WIDTH-1:0] w_q;
    logic [N_IN-1:0][NUM_WIDTH-1:0]            a_q;
    logic [N_OUT-1:0][NUM_WIDTH-1:0]           e_q;
    logic [N_OUT-1:0][NUM_WIDTH-1:0]           z_q;
    logic [N_OUT-1:0][NUM_WIDTH-1:0]           y_q;
    logic                                      act_q;
    logic                                      busy_q;
    logic                                      done_q;

    logic                        host_in_range_s;
    logic [IA-1:0]               host_i_s;
    logic [IO-1:0]               host_j_s;
    logic signed [NUM_WIDTH-1:0] mac_x_s, mac_y_s, mac_out_s;
    logic                        mac_clear_s;
    logic signed [NUM_WIDTH-1:0] upd_w_s, act_s;
    logic                        last_i_s, last_j_s;

    // Host addressing: an index outside the array reads 0 and never writes
    always_comb begin
        host_in_range_s = (32'(bus.w_i) < 32'(N_IN)) && (32'(bus.w_j) < 32'(N_OUT));
        host_i_s        = bus.w_i[IA-1:0];
        host_j_s        = bus.w_j[IO-1:0];
    end

    assign bus.w_out = host_in_range_s ? w_q[host_i_s][host_j_s] : {NUM_WIDTH{1'b0}};
    assign bus.z_pk  = z_q;
    assign bus.y_pk  = y_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // The update pass borrows the MAC with clear set to obtain the bare product a[i]*e[j]
    always_comb begin
        last_i_s = (i_q == I_LAST);
        last_j_s = (j_q == J_LAST);
        if (state_q == UPD) begin
            mac_x_s     = signed'(a_q[i_q]);
            mac_y_s     = signed'(e_q[j_q]);
            mac_clear_s = 1'b1;
        end else begin
            mac_x_s     = signed'(w_q[i_q][j_q]);
            mac_y_s     = signed'(a_q[i_q]);
            mac_clear_s = (i_q == {IA{1'b0}});
        end
    end

    fxp_mac_sat #(
        .NUM_WIDTH (NUM_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .acc_i   (acc_q),
        .x_i     (mac_x_s),
        .y_i     (mac_y_s),
        .clear_i (mac_clear_s),
        .acc_o   (mac_out_s)
    );

    // Post-MAC results: delta-rule weight and selected activation
    always_comb begin
        upd_w_s = NUM_WIDTH'(sat_sub(wide_t'(signed'(w_q[i_q][j_q])),
                                     wide_t'(mac_out_s) >>> LR_SHIFT, NUM_WIDTH));
        if (act_q) begin
            act_s = NUM_WIDTH'(leaky_relu(wide_t'(mac_out_s)));
        end else begin
            act_s = mac_out_s;
        end
    end

    // Next state and loop counters: i is the inner index, j the outer
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                i_d = {IA{1'b0}};
                j_d = {IO{1'b0}};
                if (bus.start) begin
                    state_d = bus.mode ? UPD : FWD;
                end else begin
                    state_d = IDLE;
                end
            end
            FWD, UPD: begin
                if (state_q == FWD) begin
                    acc_d = mac_out_s;
                end else begin
                    acc_d = acc_q;
                end
                if (last_i_s) begin
                    i_d = {IA{1'b0}};
                    if (last_j_s) begin
                        j_d     = {IO{1'b0}};
                        state_d = DONE;
                    end else begin
                        j_d = j_q + IO'(1'b1);
                    end
                end else begin
                    i_d = i_q + IA'(1'b1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered state, status flags, latched operands, weights and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= {IA{1'b0}};
            j_q     <= {IO{1'b0}};
            acc_q   <= {NUM_WIDTH{1'b0}};
            w_q     <= '0;
            a_q     <= '0;
            e_q     <= '0;
            z_q     <= '0;
            y_q     <= '0;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            busy_q  <= (state_d == FWD) || (state_d == UPD);
            done_q  <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.wu && host_in_range_s) begin
                        w_q[host_i_s][host_j_s] <= bus.w_in;
                    end
                    if (bus.start) begin
                        a_q   <= bus.a_pk;
                        e_q   <= bus.e_pk;
                        act_q <= bus.act_sel;
                    end
                end
                FWD: begin
                    if (last_i_s) begin
                        z_q[j_q] <= mac_out_s;
                        y_q[j_q] <= act_s;
                    end
                end
                UPD: begin
                    w_q[i_q][j_q] <= upd_w_s;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed self-checking bench for dense_layer_seq with a 2x2 layer, Q8.8 words.
module tb_dense_layer_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dense_layer_seq_if #(.N_IN(2), .N_OUT(2), .NUM_WIDTH(16), .INDEX_WIDTH(4)) bus ();

    dense_layer_seq #(
        .N_IN(2), .N_OUT(2), .NUM_WIDTH(16), .FRAC_BITS(8), .LR_SHIFT(4), .INDEX_WIDTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic write_w(input int i, input int j, input logic [15:0] v);
        bus.wu = 1'b1; bus.w_i = 4'(i); bus.w_j = 4'(j); bus.w_in = v;
        @(posedge clk); #1;
        bus.wu = 1'b0;
    endtask

    task automatic pulse_start(input logic md, input logic act, input logic [31:0] a,
                               input logic [31:0] e);
        bus.start = 1'b1; bus.mode = md; bus.act_sel = act; bus.a_pk = a; bus.e_pk = e;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // cnt counts clock edges from the start-sampling edge to done becoming visible
    task automatic wait_done(output int cnt, output bit seen);
        cnt = 1; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic test_reset();
        logic [15:0] expw [4];
        write_w(0, 0, 16'h1234);
        bus.w_i = 4'd0; bus.w_j = 4'd0; #1;
        checks++;
        if (bus.w_out !== 16'h1234) begin errors++; $display("FAIL reset_pre_w00 got %h want 1234", bus.w_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.z_pk !== 32'h0 || bus.y_pk !== 32'h0) begin errors++; $display("FAIL reset_zy got z=%h y=%h want 0", bus.z_pk, bus.y_pk); end
        checks++;
        if (bus.w_out !== 16'h0) begin errors++; $display("FAIL reset_wout got %h want 0", bus.w_out); end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        expw = '{16'h0, 16'h0, 16'h0, 16'h0};
        for (int k = 0; k < 4; k++) begin
            bus.w_i = 4'(k / 2); bus.w_j = 4'(k % 2); #1;
            checks++;
            if (bus.w_out !== expw[k]) begin errors++; $display("FAIL reset_w%0d%0d got %h want %h", k / 2, k % 2, bus.w_out, expw[k]); end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        int cnt; bit seen;
        write_w(0, 0, 16'h0100); write_w(1, 0, 16'h0200);
        write_w(0, 1, 16'hFF00); write_w(1, 1, 16'h0080);
        pulse_start(1'b0, 1'b1, {16'h0080, 16'h0100}, 32'h0);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL fwd_busy got %b want 1", bus.busy); end
        wait_done(cnt, seen);
        checks++;
        if (!seen || cnt != 5) begin errors++; $display("FAIL fwd_latency got seen=%b cnt=%0d want 1 5", seen, cnt); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL fwd_busy_at_done got %b want 0", bus.busy); end
        checks++;
        if (bus.z_pk !== {16'hFF40, 16'h0200}) begin errors++; $display("FAIL fwd_z got %h want ff400200", bus.z_pk); end
        checks++;
        if (bus.y_pk !== {16'hFFE8, 16'h0200}) begin errors++; $display("FAIL fwd_y got %h want ffe80200", bus.y_pk); end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL fwd_after_done got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int cnt; bit seen;
        // start and a host write in the same IDLE cycle: the pass sees w00 = 2.0
        bus.wu = 1'b1; bus.w_i = 4'd0; bus.w_j = 4'd0; bus.w_in = 16'h0200;
        pulse_start(1'b0, 1'b0, {16'h0080, 16'h0100}, 32'h0);
        bus.wu = 1'b0;
        wait_done(cnt, seen);
        checks++;
        if (!seen || cnt != 5) begin errors++; $display("FAIL b2b_latency1 got seen=%b cnt=%0d want 1 5", seen, cnt); end
        checks++;
        if (bus.z_pk !== {16'hFF40, 16'h0300}) begin errors++; $display("FAIL b2b_z_identity got %h want ff400300", bus.z_pk); end
        checks++;
        if (bus.y_pk !== {16'hFF40, 16'h0300}) begin errors++; $display("FAIL b2b_y_identity got %h want ff400300", bus.y_pk); end
        @(posedge clk); #1;
        pulse_start(1'b0, 1'b1, {16'h0080, 16'h0100}, 32'h0);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
        wait_done(cnt, seen);
        checks++;
        if (!seen || cnt != 5) begin errors++; $display("FAIL b2b_latency2 got seen=%b cnt=%0d want 1 5", seen, cnt); end
        checks++;
        if (bus.y_pk !== {16'hFFE8, 16'h0300}) begin errors++; $display("FAIL b2b_y_leaky got %h want ffe80300", bus.y_pk); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int cnt; bit seen;
        for (int k = 0; k < 4; k++) write_w(k / 2, k % 2, 16'h7FFF);
        pulse_start(1'b0, 1'b0, {16'h7FFF, 16'h7FFF}, 32'h0);
        wait_done(cnt, seen);
        checks++;
        if (!seen || bus.z_pk !== {16'h7FFF, 16'h7FFF}) begin errors++; $display("FAIL sat_pos got seen=%b z=%h want 7fff7fff", seen, bus.z_pk); end
        @(posedge clk); #1;
        pulse_start(1'b0, 1'b0, {16'h8000, 16'h8000}, 32'h0);
        wait_done(cnt, seen);
        checks++;
        if (!seen || bus.z_pk !== {16'h8000, 16'h8000}) begin errors++; $display("FAIL sat_neg got seen=%b z=%h want 80008000", seen, bus.z_pk); end
        @(posedge clk); #1;
    endtask

    task automatic test_update();
        int cnt; bit seen;
        logic [15:0] expw [4];
        write_w(0, 0, 16'h0100);
        pulse_start(1'b1, 1'b0, {16'h0000, 16'h0100}, {16'h0000, 16'h0100});
        wait_done(cnt, seen);
        checks++;
        if (!seen || cnt != 5) begin errors++; $display("FAIL upd_latency got seen=%b cnt=%0d want 1 5", seen, cnt); end
        checks++;
        if (bus.z_pk !== {16'h8000, 16'h8000}) begin errors++; $display("FAIL upd_z_untouched got %h want 80008000", bus.z_pk); end
        expw = '{16'h00F0, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        for (int k = 0; k < 4; k++) begin
            bus.w_i = 4'(k / 2); bus.w_j = 4'(k % 2); #1;
            checks++;
            if (bus.w_out !== expw[k]) begin errors++; $display("FAIL upd_w%0d%0d got %h want %h", k / 2, k % 2, bus.w_out, expw[k]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        logic [15:0] expw [4];
        write_w(0, 0, 16'h0011); write_w(0, 1, 16'h0033);
        write_w(1, 0, 16'h0022); write_w(1, 1, 16'h0044);
        write_w(2, 0, 16'h1234);
        write_w(0, 2, 16'h1234);
        bus.w_i = 4'd2; bus.w_j = 4'd0; #1;
        checks++;
        if (bus.w_out !== 16'h0) begin errors++; $display("FAIL oor_read_i got %h want 0", bus.w_out); end
        bus.w_i = 4'd1; bus.w_j = 4'd2; #1;
        checks++;
        if (bus.w_out !== 16'h0) begin errors++; $display("FAIL oor_read_j got %h want 0", bus.w_out); end
        expw = '{16'h0011, 16'h0033, 16'h0022, 16'h0044};
        for (int k = 0; k < 4; k++) begin
            bus.w_i = 4'(k / 2); bus.w_j = 4'(k % 2); #1;
            checks++;
            if (bus.w_out !== expw[k]) begin errors++; $display("FAIL oor_w%0d%0d got %h want %h", k / 2, k % 2, bus.w_out, expw[k]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_protocol();
        int cnt; bit seen;
        pulse_start(1'b0, 1'b0, {16'h0100, 16'h0100}, 32'h0);
        cnt = 1; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) begin seen = 1'b1; break; end
            if (cnt == 2) begin
                bus.start = 1'b1; bus.mode = 1'b1;
                bus.wu = 1'b1; bus.w_i = 4'd1; bus.w_j = 4'd0; bus.w_in = 16'h5555;
            end else begin
                bus.start = 1'b0; bus.wu = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        bus.start = 1'b0; bus.wu = 1'b0;
        checks++;
        if (!seen || cnt != 5) begin errors++; $display("FAIL proto_latency got seen=%b cnt=%0d want 1 5", seen, cnt); end
        checks++;
        if (bus.z_pk !== {16'h0077, 16'h0033}) begin errors++; $display("FAIL proto_z got %h want 00770033", bus.z_pk); end
        bus.w_i = 4'd1; bus.w_j = 4'd0; #1;
        checks++;
        if (bus.w_out !== 16'h0022) begin errors++; $display("FAIL proto_busy_write got %h want 0022", bus.w_out); end
        @(posedge clk); #1;
        // reset in the middle of a forward pass
        pulse_start(1'b0, 1'b0, {16'h0100, 16'h0100}, 32'h0);
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL proto_rst_flags got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        checks++;
        if (bus.z_pk !== 32'h0 || bus.y_pk !== 32'h0) begin errors++; $display("FAIL proto_rst_zy got z=%h y=%h want 0", bus.z_pk, bus.y_pk); end
        for (int k = 0; k < 4; k++) begin
            bus.w_i = 4'(k / 2); bus.w_j = 4'(k % 2); #1;
            checks++;
            if (bus.w_out !== 16'h0) begin errors++; $display("FAIL proto_rst_w%0d%0d got %h want 0", k / 2, k % 2, bus.w_out); end
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL proto_no_done got activity=%b want 0", seen); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.act_sel = 1'b0;
        bus.a_pk = 32'h0; bus.e_pk = 32'h0;
        bus.wu = 1'b0; bus.w_i = 4'd0; bus.w_j = 4'd0; bus.w_in = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_forward();
        test_back_to_back();
        test_saturation();
        test_update();
        test_out_of_range();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
